// File: rtl/clk_div_pkg.sv
// Shared constants and helpers for the programmable clock divider bank.
package clk_div_pkg;

  localparam logic MODE_SQUARE = 1'b0;
  localparam logic MODE_PULSE  = 1'b1;

  function automatic int ch_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: counter, active/shadow target, square or pulse output.
// Outputs change on the edge that zeroes the counter; config writes never stall here.
module clk_div_channel
  import clk_div_pkg::*;
#(
  parameter int unsigned          BIT_WIDTH    = 32,
  parameter logic [BIT_WIDTH-1:0] RESET_TARGET = '0
) (
  input  logic                 clk_in,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 mode,
  input  logic                 wr_en,
  input  logic [BIT_WIDTH-1:0] wr_target,
  output logic [BIT_WIDTH-1:0] cnt,
  output logic                 clk_out,
  output logic                 tick,
  output logic                 pending
);

  logic [BIT_WIDTH-1:0] active_target;
  logic [BIT_WIDTH-1:0] shadow_target;
  logic                 wrap;

  assign wrap = (cnt >= active_target);

  always_ff @(posedge clk_in) begin
    if (!reset) begin
      cnt           <= '0;
      clk_out       <= 1'b0;
      tick          <= 1'b0;
      active_target <= RESET_TARGET;
      shadow_target <= '0;
      pending       <= 1'b0;
    end else if (!enable) begin
      cnt     <= '0;
      clk_out <= 1'b0;
      tick    <= 1'b0;
      pending <= 1'b0;
      // Idle channel: the target can change immediately without a glitch.
      if (wr_en) begin
        active_target <= wr_target;
      end else if (pending) begin
        active_target <= shadow_target;
      end
    end else begin
      if (wrap) begin
        cnt  <= '0;
        tick <= 1'b1;
        case (mode)
          MODE_SQUARE: clk_out <= ~clk_out;
          MODE_PULSE:  clk_out <= 1'b1;
          default:     clk_out <= 1'b0;
        endcase
        if (pending) begin
          active_target <= shadow_target;
          pending       <= 1'b0;
        end
      end else begin
        cnt  <= cnt + BIT_WIDTH'(1);
        tick <= 1'b0;
        if (mode == MODE_PULSE) begin
          clk_out <= 1'b0;
        end
      end
      // A write on the wrap edge is only shadowed; it applies at the next wrap.
      if (wr_en) begin
        shadow_target <= wr_target;
        pending       <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/clk_div_bank.sv
// Bank of NUM_CH programmable dividers sharing one valid/ready config port.
// Outputs registered, change on each channel's wrap edge; cfg_ready low while the addressed channel holds a pending target.
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int unsigned          BIT_WIDTH    = 32,
  parameter int unsigned          NUM_CH       = 4,
  parameter logic [BIT_WIDTH-1:0] RESET_TARGET = '0
) (
  input  logic                          clk_in,
  input  logic                          reset,
  input  logic [NUM_CH-1:0]             enable,
  input  logic [NUM_CH-1:0]             mode,
  input  logic                          cfg_valid,
  input  logic [ch_width(NUM_CH)-1:0]   cfg_ch,
  input  logic [BIT_WIDTH-1:0]          cfg_target,
  output logic                          cfg_ready,
  output logic [NUM_CH-1:0]             clk_out,
  output logic [NUM_CH-1:0]             tick,
  output logic [NUM_CH*BIT_WIDTH-1:0]   cnt_out
);

  localparam int CH_W  = ch_width(NUM_CH);
  localparam int PAD_W = 1 << CH_W;

  logic [NUM_CH-1:0] pending;
  logic [PAD_W-1:0]  pending_pad;

  // Unused channel addresses read as not-pending, so writes to them are swallowed.
  assign pending_pad = PAD_W'(pending);
  assign cfg_ready   = ~pending_pad[cfg_ch];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic wr_en;

    assign wr_en = cfg_valid && cfg_ready && (cfg_ch == CH_W'(i));

    clk_div_channel #(
      .BIT_WIDTH    (BIT_WIDTH),
      .RESET_TARGET (RESET_TARGET)
    ) u_ch (
      .clk_in    (clk_in),
      .reset     (reset),
      .enable    (enable[i]),
      .mode      (mode[i]),
      .wr_en     (wr_en),
      .wr_target (cfg_target),
      .cnt       (cnt_out[i*BIT_WIDTH +: BIT_WIDTH]),
      .clk_out   (clk_out[i]),
      .tick      (tick[i]),
      .pending   (pending[i])
    );
  end

endmodule

// File: tb/tb_clk_div_bank.sv
// Directed bench for clk_div_bank with a per-cycle reference model.
module tb_clk_div_bank;

  localparam int BW = 8;
  localparam int NC = 4;

  logic          clk_in = 1'b0;
  logic          reset;
  logic [NC-1:0] enable, mode;
  logic          cfg_valid;
  logic [1:0]    cfg_ch;
  logic [BW-1:0] cfg_target;
  logic          cfg_ready;
  logic [NC-1:0] clk_out, tick;
  logic [NC*BW-1:0] cnt_out;

  // Second, non-power-of-two instance for out-of-range addresses.
  logic [2:0]    enable2, mode2;
  logic          cfg_valid2;
  logic [1:0]    cfg_ch2;
  logic [BW-1:0] cfg_target2;
  logic          cfg_ready2;
  logic [2:0]    clk_out2, tick2;
  logic [3*BW-1:0] cnt_out2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk_in = ~clk_in;

  clk_div_bank #(.BIT_WIDTH(BW), .NUM_CH(NC), .RESET_TARGET(8'd0)) dut (
    .clk_in(clk_in), .reset(reset), .enable(enable), .mode(mode),
    .cfg_valid(cfg_valid), .cfg_ch(cfg_ch), .cfg_target(cfg_target),
    .cfg_ready(cfg_ready), .clk_out(clk_out), .tick(tick), .cnt_out(cnt_out)
  );

  clk_div_bank #(.BIT_WIDTH(BW), .NUM_CH(3), .RESET_TARGET(8'd0)) dut3 (
    .clk_in(clk_in), .reset(reset), .enable(enable2), .mode(mode2),
    .cfg_valid(cfg_valid2), .cfg_ch(cfg_ch2), .cfg_target(cfg_target2),
    .cfg_ready(cfg_ready2), .clk_out(clk_out2), .tick(tick2), .cnt_out(cnt_out2)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  // Reference model: counter advances modulo (target+1); a wrap is the cycle the count equals target.
  int m_cnt[NC], m_tgt[NC], m_shd[NC];
  bit m_pend[NC], m_clk[NC], m_tick[NC];
  bit m_valid = 0;

  always @(posedge clk_in) begin
    bit acc, hit, wrap;
    acc = cfg_valid && !m_pend[cfg_ch];
    for (int i = 0; i < NC; i++) begin
      hit = acc && (int'(cfg_ch) == i);
      if (!reset) begin
        m_cnt[i] = 0; m_tgt[i] = 0; m_shd[i] = 0;
        m_pend[i] = 0; m_clk[i] = 0; m_tick[i] = 0;
      end else if (!enable[i]) begin
        if (hit) m_tgt[i] = int'(cfg_target);
        else if (m_pend[i]) m_tgt[i] = m_shd[i];
        m_pend[i] = 0; m_cnt[i] = 0; m_clk[i] = 0; m_tick[i] = 0;
      end else begin
        wrap      = (m_cnt[i] == m_tgt[i]);
        m_cnt[i]  = (m_cnt[i] + 1) % (m_tgt[i] + 1);
        m_tick[i] = wrap;
        m_clk[i]  = mode[i] ? wrap : (m_clk[i] ^ wrap);
        if (wrap && m_pend[i]) begin
          m_tgt[i]  = m_shd[i];
          m_pend[i] = 0;
        end
        if (hit) begin
          m_shd[i]  = int'(cfg_target);
          m_pend[i] = 1;
        end
      end
    end
    m_valid = 1;
  end

  initial begin
    logic [NC*BW-1:0] e_cnt;
    logic [NC-1:0]    e_clk, e_tick;
    forever begin
      @(posedge clk_in);
      #2;
      if (m_valid) begin
        for (int i = 0; i < NC; i++) begin
          e_cnt[i*BW +: BW] = BW'(m_cnt[i]);
          e_clk[i]          = m_clk[i];
          e_tick[i]         = m_tick[i];
        end
        chk("model cnt_out", 64'(cnt_out), 64'(e_cnt));
        chk("model clk_out", 64'(clk_out), 64'(e_clk));
        chk("model tick", 64'(tick), 64'(e_tick));
        chk("model cfg_ready", 64'(cfg_ready), 64'(!m_pend[cfg_ch]));
      end
    end
  end

  initial begin
    int hi, tk;
    int seq [6];
    reset = 1'b0; enable = 4'b0001; mode = 4'b0000;
    cfg_valid = 1'b0; cfg_ch = 2'd0; cfg_target = '0;
    enable2 = 3'b111; mode2 = 3'b000; cfg_valid2 = 1'b0; cfg_ch2 = 2'd0; cfg_target2 = '0;

    // Reset default, target 0 on ch0
    step(3);
    chk("reset cnt_out", 64'(cnt_out), 64'h0);
    chk("reset clk_out", 64'(clk_out), 64'h0);
    chk("reset tick", 64'(tick), 64'h0);
    reset = 1'b1;
    step(1);
    chk("t0 clk_out first", 64'(clk_out), 64'b0001);
    chk("t0 tick first", 64'(tick), 64'b0001);
    step(1);
    chk("t0 clk_out second", 64'(clk_out), 64'b0000);
    chk("t0 tick second", 64'(tick), 64'b0001);

    // Square divide on ch1, target 4
    cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_target = 8'd4;
    step(1);
    chk("ch1 direct write ready", 64'(cfg_ready), 64'h1);
    cfg_valid = 1'b0; enable[1] = 1'b1;
    seq = '{0, 1, 2, 3, 4, 0};
    for (int k = 0; k < 6; k++) begin
      chk("ch1 cnt seq", 64'(cnt_out[15:8]), 64'(seq[k]));
      step(1);
    end
    hi = 0; tk = 0;
    for (int k = 0; k < 20; k++) begin
      hi += int'(clk_out[1]); tk += int'(tick[1]);
      step(1);
    end
    chk("ch1 high cycles /20", 64'(hi), 64'd10);
    chk("ch1 ticks /20", 64'(tk), 64'd4);

    // Pulse mode on ch2, target 2
    cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_target = 8'd2; mode[2] = 1'b1;
    step(1);
    cfg_valid = 1'b0; enable[2] = 1'b1;
    step(1);
    hi = 0; tk = 0;
    for (int k = 0; k < 12; k++) begin
      hi += int'(clk_out[2]); tk += int'(tick[2]);
      step(1);
    end
    chk("ch2 pulses /12", 64'(hi), 64'd4);
    chk("ch2 ticks /12", 64'(tk), 64'd4);

    // Shadow update on ch0: target 7, rewrite to 3 at count 2
    enable[0] = 1'b0; cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_target = 8'd7;
    step(1);
    cfg_valid = 1'b0; enable[0] = 1'b1;
    step(2);
    chk("ch0 cnt before write", 64'(cnt_out[7:0]), 64'd2);
    cfg_valid = 1'b1; cfg_target = 8'd3;
    step(1);
    chk("ch0 ready after write", 64'(cfg_ready), 64'h0);
    cfg_valid = 1'b0;
    step(4);
    chk("ch0 reaches old target", 64'(cnt_out[7:0]), 64'd7);
    chk("ch0 no tick at 7", 64'(tick[0]), 64'h0);
    step(1);
    chk("ch0 wrap at old target", 64'(tick[0]), 64'h1);
    chk("ch0 ready after wrap", 64'(cfg_ready), 64'h1);
    step(3);
    chk("ch0 no tick mid", 64'(tick[0]), 64'h0);
    step(1);
    chk("ch0 wrap every 4", 64'(tick[0]), 64'h1);

    // Write on the wrap edge, then a stalled second write
    step(3);
    chk("ch0 cnt before collision", 64'(cnt_out[7:0]), 64'd3);
    cfg_valid = 1'b1; cfg_target = 8'd5;
    step(1);
    chk("collision tick", 64'(tick[0]), 64'h1);
    chk("collision pending", 64'(cfg_ready), 64'h0);
    cfg_target = 8'd2;
    step(4);
    chk("still old target wrap", 64'(tick[0]), 64'h1);
    chk("stalled write sees ready", 64'(cfg_ready), 64'h1);
    step(1);
    chk("stalled write taken", 64'(cfg_ready), 64'h0);
    chk("ch0 cnt after stall", 64'(cnt_out[7:0]), 64'd1);
    cfg_valid = 1'b0;
    step(4);
    chk("target5 no tick", 64'(tick[0]), 64'h0);
    chk("target5 cnt", 64'(cnt_out[7:0]), 64'd5);
    step(1);
    chk("target5 wrap", 64'(tick[0]), 64'h1);
    step(2);
    chk("target2 no tick", 64'(tick[0]), 64'h0);
    step(1);
    chk("target2 wrap", 64'(tick[0]), 64'h1);

    // Disable with pending shadow on ch3
    cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_target = 8'd9;
    step(1);
    cfg_valid = 1'b0; enable[3] = 1'b1;
    step(2);
    chk("ch3 cnt 2", 64'(cnt_out[31:24]), 64'd2);
    cfg_valid = 1'b1; cfg_target = 8'd4;
    step(1);
    chk("ch3 pending", 64'(cfg_ready), 64'h0);
    cfg_valid = 1'b0;
    step(2);
    chk("ch3 cnt 5", 64'(cnt_out[31:24]), 64'd5);
    enable[3] = 1'b0;
    step(1);
    chk("ch3 disabled cnt", 64'(cnt_out[31:24]), 64'd0);
    chk("ch3 shadow applied", 64'(cfg_ready), 64'h1);
    enable[3] = 1'b1;
    step(4);
    chk("ch3 reenable no tick", 64'(tick[3]), 64'h0);
    step(1);
    chk("ch3 first wrap", 64'(tick[3]), 64'h1);

    // Mid-operation reset with pending set on ch3
    enable[3] = 1'b0; cfg_valid = 1'b1; cfg_target = 8'd9;
    step(1);
    cfg_valid = 1'b0; enable[3] = 1'b1;
    step(2);
    chk("ch3 cnt 2 again", 64'(cnt_out[31:24]), 64'd2);
    cfg_valid = 1'b1; cfg_target = 8'd6;
    step(1);
    chk("ch3 pending again", 64'(cfg_ready), 64'h0);
    cfg_valid = 1'b0;
    step(2);
    chk("ch3 cnt 5 again", 64'(cnt_out[31:24]), 64'd5);
    reset = 1'b0;
    step(1);
    chk("mid reset cnt_out", 64'(cnt_out), 64'h0);
    chk("mid reset clk_out", 64'(clk_out), 64'h0);
    chk("mid reset tick", 64'(tick), 64'h0);
    chk("mid reset pending", 64'(cfg_ready), 64'h1);
    reset = 1'b1;
    step(1);
    chk("post reset tick", 64'(tick), 64'b1111);
    chk("post reset clk_out", 64'(clk_out), 64'b1111);
    step(1);
    chk("post reset tick 2", 64'(tick), 64'b1111);
    chk("post reset clk_out 2", 64'(clk_out), 64'b0100);

    // Out-of-range channel on a 3-channel bank
    cfg_ch2 = 2'd3; cfg_valid2 = 1'b1; cfg_target2 = 8'd7;
    #1;
    chk("oob ready", 64'(cfg_ready2), 64'h1);
    step(1);
    cfg_valid2 = 1'b0;
    for (int c = 0; c < 3; c++) begin
      cfg_ch2 = 2'(c);
      #1;
      chk("oob no pending", 64'(cfg_ready2), 64'h1);
    end
    step(1);
    chk("oob ticks unchanged", 64'(tick2), 64'b111);
    chk("oob counters", 64'(cnt_out2), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
